// File: rtl/apb_cmp_pkg.sv
// Shared types and address-map constants for the APB completer register block.
package apb_cmp_pkg;

   // Registered phase of the completer: reflects what the last sampled edge saw on the bus.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_phase_e;

   // Word offsets (Paddr[6:2]) of the special registers.
   localparam logic [4:0] OFS_STATUS = 5'h10;
   localparam logic [4:0] OFS_ERR    = 5'h11;

   // Copy of the setup-phase request, held so the access phase can be checked against it.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
   } apb_req_s;

endpackage

// File: rtl/apb_phase_tracker.sv
// Tracks the APB setup/access handshake for one select lane, latches the setup request,
// flags protocol violations and emits single-cycle commit strobes for the register file.
module apb_phase_tracker
   import apb_cmp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        sel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] paddr_i,
   input  logic [31:0] pwdata_i,
   output logic        setup_o,
   output logic        err_o,
   output logic        wr_commit_o,
   output logic        rd_commit_o,
   output logic        rd_load_o,
   output logic [4:0]  commit_ofs_o,
   output logic [31:0] commit_data_o
);

   apb_phase_e state_q, state_d;
   apb_req_s   req_q, req_d;
   apb_req_s   cur_req;
   logic       match;
   logic       commit;

   assign cur_req = '{addr: paddr_i, write: pwrite_i, wdata: pwdata_i};
   assign match   = (cur_req == req_q);

   // Phase and latched setup request; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   // Next phase: a setup cycle always (re)latches; only a matching access completes.
   always_comb begin
      state_d = IDLE;
      req_d   = req_q;
      case (state_q)
         SETUP: begin
            if (sel_i && penable_i && match) begin
               state_d = ACCESS;
            end else if (sel_i && !penable_i) begin
               state_d = SETUP;
               req_d   = cur_req;
            end
         end
         default: begin
            if (sel_i && !penable_i) begin
               state_d = SETUP;
               req_d   = cur_req;
            end
         end
      endcase
   end

   // Error and commit decode: anything other than a clean access after setup is a violation.
   always_comb begin
      err_o  = 1'b0;
      commit = 1'b0;
      case (state_q)
         SETUP: begin
            if (sel_i && penable_i) begin
               commit = match;
               err_o  = !match;
            end else begin
               err_o  = 1'b1;
            end
         end
         default: err_o = sel_i && penable_i;
      endcase
   end

   assign wr_commit_o   = commit && req_q.write;
   assign rd_commit_o   = commit && !req_q.write;
   assign rd_load_o     = sel_i && !penable_i && !pwrite_i;
   assign setup_o       = (state_q == SETUP);
   assign commit_ofs_o  = req_q.addr[6:2];
   assign commit_data_o = req_q.wdata;

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer on one select lane: scratch registers, transfer counters, a saturating
// protocol-error counter with clear-on-write, and zero-wait-state read data.
module apb_reg_completer
   import apb_cmp_pkg::*;
#(
   parameter int SEL_IDX  = 0,
   parameter int NUM_REGS = 8,
   parameter int ERR_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        err_irq
);

   logic              sel;
   logic              unused_psel;
   logic              trk_setup, trk_err, wr_commit, rd_commit, rd_load;
   logic [4:0]        commit_ofs;
   logic [31:0]       commit_data;
   logic [31:0]       regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] reg_we;
   logic [15:0]       wr_cnt_q, rd_cnt_q;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              err_clr;
   logic              err_irq_q;
   logic [31:0]       rd_q, rd_val;

   // Other select bits belong to sibling completers; they are deliberately ignored here.
   assign sel         = Pselx[SEL_IDX];
   assign unused_psel = ^Pselx;

   apb_phase_tracker u_trk (
      .clk           (clk),
      .rst           (rst),
      .sel_i         (sel),
      .penable_i     (Penable),
      .pwrite_i      (Pwrite),
      .paddr_i       (Paddr),
      .pwdata_i      (Pwdata),
      .setup_o       (trk_setup),
      .err_o         (trk_err),
      .wr_commit_o   (wr_commit),
      .rd_commit_o   (rd_commit),
      .rd_load_o     (rd_load),
      .commit_ofs_o  (commit_ofs),
      .commit_data_o (commit_data)
   );

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign reg_we[gi] = wr_commit && (commit_ofs == 5'(gi));
   end

   // Read mux, addressed by the live setup-phase address; unmapped offsets read zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (Paddr[6:2] == 5'(i)) rd_val = regs_q[i];
      end
      if (Paddr[6:2] == OFS_STATUS) rd_val = {rd_cnt_q, wr_cnt_q};
      if (Paddr[6:2] == OFS_ERR)    rd_val = 32'(err_cnt_q);
   end

   // Error counter next value: a clear never hides an error on the same edge.
   always_comb begin
      err_clr   = wr_commit && (commit_ofs == OFS_ERR);
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = ERR_W'(trk_err);
      end else if (trk_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   // Scratch registers, counters, read-data capture and the interrupt level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         err_cnt_q <= '0;
         err_irq_q <= 1'b0;
         rd_q      <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_we[i]) regs_q[i] <= commit_data;
         end
         if (wr_commit) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (rd_commit) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (rd_load)   rd_q     <= rd_val;
         err_cnt_q <= err_cnt_d;
         err_irq_q <= |err_cnt_d;
      end
   end

   // Read data is driven only during the access cycle of a read.
   assign Prdata  = (trk_setup && sel && Penable && !Pwrite) ? rd_q : 32'd0;
   assign err_irq = err_irq_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Testbench for apb_reg_completer: directed vector table, corner-case sequences,
// then randomized transactions checked against a transaction-level model.
module tb_apb_reg_completer;

   localparam int NREGS = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        err_irq;

   int checks   = 0;
   int failures = 0;

   // transaction-level model state
   logic [31:0] mem [NREGS];
   int          m_wr, m_rd, m_err;

   typedef struct {
      logic [2:0]  psel;
      logic        en;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_prd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl [22];

   apb_reg_completer #(.SEL_IDX(0), .NUM_REGS(NREGS), .ERR_W(8)) dut (
      .clk     (clk),
      .rst     (rst_n),
      .Pselx   (Pselx),
      .Penable (Penable),
      .Pwrite  (Pwrite),
      .Paddr   (Paddr),
      .Pwdata  (Pwdata),
      .Prdata  (Prdata),
      .err_irq (err_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end else begin
         $display("ok   %s value=%08h", name, act);
      end
   endtask

   // One bus cycle: drive at posedge+1, sample Prdata mid-cycle, return at next posedge+1.
   task automatic cyc(input logic [2:0] ps, input logic en, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] prd);
      Pselx = ps; Penable = en; Pwrite = wr; Paddr = a; Pwdata = d;
      @(negedge clk);
      prd = Prdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      logic [31:0] p;
      cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, p);
   endtask

   task automatic wr_xfer(input logic [2:0] ps, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] p;
      cyc(ps, 1'b0, 1'b1, a, d, p);
      cyc(ps, 1'b1, 1'b1, a, d, p);
   endtask

   task automatic rd_xfer(input logic [31:0] a, output logic [31:0] p_setup, output logic [31:0] p_acc);
      cyc(3'b001, 1'b0, 1'b0, a, 32'h0, p_setup);
      cyc(3'b001, 1'b1, 1'b0, a, 32'h0, p_acc);
   endtask

   task automatic do_reset();
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] off);
      if (int'(off) < NREGS) return mem[off[2:0]];
      if (off == 5'h10)      return {16'(m_rd), 16'(m_wr)};
      if (off == 5'h11)      return 32'(m_err);
      return 32'h0;
   endfunction

   function automatic void model_write(input logic [4:0] off, input logic [31:0] d);
      if (int'(off) < NREGS) mem[off[2:0]] = d;
      if (off == 5'h11) m_err = 0;
      m_wr = (m_wr + 1) & 16'hFFFF;
   endfunction

   function automatic void model_err();
      if (m_err < 255) m_err = m_err + 1;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NREGS; i++) mem[i] = 32'h0;
      m_wr = 0; m_rd = 0; m_err = 0;
   endfunction

   initial begin
      logic [31:0] p, ps_v, pa_v, exp, a, a2, d, d2;
      logic [4:0]  off, off2;
      logic [2:0]  oth;
      logic        w2;
      int          op;

      rst_n = 1'b0;
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_prdata", Prdata, 32'h0);
      check("reset_irq", 32'(err_irq), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---------------- directed vector table ----------------
      tbl[0]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[1]  = '{3'b001, 1'b0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[2]  = '{3'b001, 1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[3]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[4]  = '{3'b001, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tbl[5]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[6]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[7]  = '{3'b001, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0001_0001, 1'b0};
      tbl[8]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0000_0000, 1'b0};
      tbl[9]  = '{3'b001, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0000_0000, 1'b0};
      tbl[10] = '{3'b001, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[11] = '{3'b001, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1234_5678, 1'b0};
      tbl[12] = '{3'b001, 1'b0, 1'b0, 32'h0000_0043, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[13] = '{3'b001, 1'b1, 1'b0, 32'h0000_0043, 32'h0000_0000, 32'h0003_0002, 1'b0};
      tbl[14] = '{3'b010, 1'b0, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[15] = '{3'b010, 1'b1, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[16] = '{3'b001, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[17] = '{3'b001, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[18] = '{3'b001, 1'b0, 1'b0, 32'h0000_007C, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[19] = '{3'b001, 1'b1, 1'b0, 32'h0000_007C, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[20] = '{3'b111, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[21] = '{3'b111, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1234_5678, 1'b0};

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].psel, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wdata, p);
         check($sformatf("vec%0d_prdata", i), p, tbl[i].exp_prd);
         check($sformatf("vec%0d_irq", i), 32'(err_irq), 32'(tbl[i].exp_irq));
      end

      // ---------------- address changed between setup and access ----------------
      cyc(3'b001, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_AAAA, p);
      cyc(3'b001, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_AAAA, p);
      check("addrchg_irq", 32'(err_irq), 32'h1);
      rd_xfer(32'h0000_0044, ps_v, pa_v);
      check("addrchg_errcnt", pa_v, 32'h1);
      rd_xfer(32'h0000_0010, ps_v, pa_v);
      check("addrchg_nocommit", pa_v, 32'h0);
      wr_xfer(3'b001, 32'h0000_0044, 32'h1234_0000);
      check("errclr_irq", 32'(err_irq), 32'h0);
      rd_xfer(32'h0000_0044, ps_v, pa_v);
      check("errclr_cnt", pa_v, 32'h0);

      // ---------------- saturation: 300 enables without setup ----------------
      for (int i = 0; i < 300; i++) cyc(3'b001, 1'b1, 1'b0, 32'h0, 32'h0, p);
      check("sat_irq", 32'(err_irq), 32'h1);
      rd_xfer(32'h0000_0044, ps_v, pa_v);
      check("sat_errcnt", pa_v, 32'h0000_00FF);
      wr_xfer(3'b001, 32'h0000_0044, 32'h0);
      check("sat_clr_irq", 32'(err_irq), 32'h0);

      // ---------------- asynchronous reset during a write access ----------------
      cyc(3'b001, 1'b1, 1'b0, 32'h0, 32'h0, p);
      check("pre_rst_irq", 32'(err_irq), 32'h1);
      cyc(3'b001, 1'b0, 1'b1, 32'h0000_0018, 32'h5555_AAAA, p);
      Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h0000_0018; Pwdata = 32'h5555_AAAA;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_irq", 32'(err_irq), 32'h0);
      check("rst_async_prdata", Prdata, 32'h0);
      @(posedge clk);
      #1;
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd_xfer(32'h0000_0040, ps_v, pa_v);
      check("rst_status", pa_v, 32'h0);
      rd_xfer(32'h0000_0018, ps_v, pa_v);
      check("rst_reg_unwritten", pa_v, 32'h0);
      check("rst_irq_after", 32'(err_irq), 32'h0);
      wr_xfer(3'b001, 32'h0000_0018, 32'h0000_0077);
      rd_xfer(32'h0000_0018, ps_v, pa_v);
      check("rst_first_xfer", pa_v, 32'h0000_0077);

      // ---------------- randomized transactions vs model ----------------
      do_reset();
      model_clear();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            oth = 3'($urandom_range(0, 7)) & 3'b110;
            cyc(oth, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, p);
         end
         op  = $urandom_range(0, 11);
         off = 5'($urandom_range(0, 31));
         a   = $urandom;
         a[6:2] = off;
         d   = $urandom;
         oth = 3'($urandom_range(0, 7)) & 3'b110;
         case (op)
            0, 1, 2, 3: begin
               wr_xfer(3'b001 | oth, a, d);
               model_write(off, d);
            end
            4, 5, 6: begin
               exp = model_read(off);
               rd_xfer(a, ps_v, pa_v);
               check($sformatf("rnd%0d_rd_setup", n), ps_v, 32'h0);
               check($sformatf("rnd%0d_rd_ofs%0h", n, off), pa_v, exp);
               m_rd = (m_rd + 1) & 16'hFFFF;
            end
            7: begin
               cyc(3'b001 | oth, 1'b1, 1'($urandom_range(0, 1)), a, d, p);
               model_err();
            end
            8: begin
               w2 = 1'($urandom_range(0, 1));
               cyc(3'b001, 1'b0, w2, a, d, p);
               a2 = a ^ (32'h1 << $urandom_range(0, 31));
               cyc(3'b001, 1'b1, w2, a2, d, p);
               model_err();
            end
            9: begin
               cyc(3'b001, 1'b0, 1'($urandom_range(0, 1)), a, d, p);
               cyc(oth, 1'($urandom_range(0, 1)), 1'b0, a, d, p);
               model_err();
            end
            10: begin
               cyc(3'b001, 1'b0, 1'($urandom_range(0, 1)), a, d, p);
               off2 = 5'($urandom_range(0, 31));
               a2 = $urandom;
               a2[6:2] = off2;
               d2 = $urandom;
               w2 = 1'($urandom_range(0, 1));
               exp = model_read(off2);
               cyc(3'b001, 1'b0, w2, a2, d2, p);
               model_err();
               cyc(3'b001, 1'b1, w2, a2, d2, p);
               if (w2) begin
                  model_write(off2, d2);
               end else begin
                  check($sformatf("rnd%0d_relatch_rd", n), p, exp);
                  m_rd = (m_rd + 1) & 16'hFFFF;
               end
            end
            default: begin
               if (oth == 3'b000) oth = 3'b100;
               wr_xfer(oth, a, d);
            end
         endcase
         check($sformatf("rnd%0d_irq", n), 32'(err_irq), 32'(m_err != 0));
      end

      // final sweep of all scratch registers and the special registers
      for (int i = 0; i < NREGS; i++) begin
         exp = model_read(5'(i));
         rd_xfer(32'(i) << 2, ps_v, pa_v);
         check($sformatf("final_reg%0d", i), pa_v, exp);
         m_rd = (m_rd + 1) & 16'hFFFF;
      end
      exp = model_read(5'h10);
      rd_xfer(32'h0000_0040, ps_v, pa_v);
      check("final_status", pa_v, exp);
      m_rd = (m_rd + 1) & 16'hFFFF;
      exp = model_read(5'h11);
      rd_xfer(32'h0000_0044, ps_v, pa_v);
      check("final_err", pa_v, exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
